// File: rtl/apple1_kbd_pkg.sv
// Shared definitions for the Apple-I keyboard sources: ASCII codes, PIA register
// selects, the paste-buffer state encoding and the case-folding helper.
package apple1_kbd_pkg;

   localparam logic [7:0] ASCII_NUL = 8'h00;
   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_CR  = 8'h0D;

   localparam logic REG_RX_DATA   = 1'b0;
   localparam logic REG_RX_STATUS = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_GAP,
      ST_FETCH,
      ST_EVAL,
      ST_PRESENT
   } kbd_state_t;

   // The Apple-I monitor and BASIC only understand upper case.
   function automatic logic [7:0] fold_case(input logic [7:0] b, input logic en);
      if (en && (b >= 8'h61) && (b <= 8'h7A)) return b - 8'h20;
      return b;
   endfunction

endpackage

// File: rtl/text_buf_ram.sv
// 2**AW x 8 text buffer: one write port, one registered read port (1-cycle latency).
module text_buf_ram #(
   parameter int AW = 13
) (
   input  logic          clk25,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk25) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/text_paste_buffer.sv
// Captures a text file from the ioctl download port and replays it, paced by an
// internal timer, as keystrokes through the PIA keyboard RX data/status registers.
module text_paste_buffer
   import apple1_kbd_pkg::*;
#(
   parameter int AW       = 13,
   parameter int CHAR_GAP = 25000,
   parameter int CR_GAP   = 2500000,
   parameter int GAPW     = 22
) (
   input  logic        clk25,
   input  logic        rst,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [AW:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        abort,
   input  logic        upcase_en,
   input  logic        cs,
   input  logic        address,
   output logic [7:0]  dout,
   output logic        busy,
   output logic        overflow
);

   localparam logic [GAPW-1:0] CHAR_GAP_V = GAPW'(CHAR_GAP);
   localparam logic [GAPW-1:0] CR_GAP_V   = GAPW'(CR_GAP);

   kbd_state_t      state, state_n;
   logic [GAPW-1:0] gap, gap_n;
   logic [AW:0]     ptr, ptr_n;
   logic [AW:0]     count, count_n;
   logic [7:0]      ascii, ascii_n;
   logic            rdy, rdy_n;
   logic            prev_cr, prev_cr_n;
   logic            overflow_n;
   logic            dl_q;

   logic            dl_rise;
   logic            data_rd;
   logic            stat_rd;
   logic            ram_we;
   logic [7:0]      ram_rdata;

   // CPU handshake: rdy is the valid flag of the held character (ascii); a data
   // read (cs && address == 0) is the consume strobe and clears it, a status
   // read only samples it. A new character is presented only after the gap.
   assign data_rd = cs && (address == REG_RX_DATA);
   assign stat_rd = cs && (address == REG_RX_STATUS);
   assign dl_rise = ioctl_download && !dl_q;
   assign ram_we  = (state == ST_LOAD) && ioctl_wr && !ioctl_addr[AW];
   assign busy    = (state != ST_IDLE);

   text_buf_ram #(.AW(AW)) u_ram (
      .clk25 (clk25),
      .we    (ram_we),
      .waddr (ioctl_addr[AW-1:0]),
      .wdata (ioctl_dout),
      .raddr (ptr[AW-1:0]),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         gap      <= '0;
         ptr      <= '0;
         count    <= '0;
         ascii    <= 8'h00;
         rdy      <= 1'b0;
         prev_cr  <= 1'b0;
         overflow <= 1'b0;
         dl_q     <= 1'b0;
      end else begin
         state    <= state_n;
         gap      <= gap_n;
         ptr      <= ptr_n;
         count    <= count_n;
         ascii    <= ascii_n;
         rdy      <= rdy_n;
         prev_cr  <= prev_cr_n;
         overflow <= overflow_n;
         dl_q     <= ioctl_download;
      end
   end

   always_comb begin
      state_n    = state;
      gap_n      = gap;
      ptr_n      = ptr;
      count_n    = count;
      ascii_n    = ascii;
      rdy_n      = data_rd ? 1'b0 : rdy;
      prev_cr_n  = prev_cr;
      overflow_n = overflow;

      case (state)
         ST_IDLE: ;
         ST_LOAD: begin
            if (ioctl_wr) begin
               if (ioctl_addr[AW]) overflow_n = 1'b1;
               else if (ioctl_addr >= count) count_n = ioctl_addr + (AW+1)'(1);
            end
            if (!ioctl_download) begin
               if (count_n == '0) begin
                  state_n = ST_IDLE;
               end else begin
                  state_n = ST_GAP;
                  gap_n   = CHAR_GAP_V;
               end
            end
         end
         ST_GAP: begin
            if (gap == '0) state_n = ST_FETCH;
            else gap_n = gap - GAPW'(1);
         end
         ST_FETCH: begin
            if (ptr == count) begin
               state_n = ST_IDLE;
            end else begin
               state_n = ST_EVAL;
               ptr_n   = ptr + (AW+1)'(1);
            end
         end
         ST_EVAL: begin
            // Default is "emit"; the skip cases fall back to FETCH instead.
            state_n = ST_PRESENT;
            rdy_n   = 1'b1;
            case (ram_rdata)
               ASCII_NUL: begin
                  state_n = ST_FETCH;
                  rdy_n   = rdy && !data_rd;
               end
               ASCII_LF: begin
                  if (prev_cr) begin
                     prev_cr_n = 1'b0;
                     state_n   = ST_FETCH;
                     rdy_n     = rdy && !data_rd;
                  end else begin
                     ascii_n = ASCII_CR;
                  end
               end
               ASCII_CR: begin
                  ascii_n   = ASCII_CR;
                  prev_cr_n = 1'b1;
               end
               default: begin
                  prev_cr_n = 1'b0;
                  ascii_n   = fold_case(ram_rdata, upcase_en);
               end
            endcase
         end
         ST_PRESENT: begin
            if (data_rd) begin
               state_n = ST_GAP;
               gap_n   = (ascii == ASCII_CR) ? CR_GAP_V : CHAR_GAP_V;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (abort && (state != ST_LOAD)) begin
         state_n = ST_IDLE;
         rdy_n   = 1'b0;
      end

      // A new download always restarts from scratch, even mid-playback.
      if (dl_rise) begin
         state_n    = ST_LOAD;
         count_n    = '0;
         ptr_n      = '0;
         overflow_n = 1'b0;
         rdy_n      = 1'b0;
         prev_cr_n  = 1'b0;
      end
   end

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) dout <= 8'h00;
      else if (data_rd) dout <= {1'b1, ascii[6:0]};
      else if (stat_rd) dout <= {rdy, 7'b0};
   end

endmodule

// File: doc/text_paste_buffer.md
Name: text_paste_buffer

Overview:
- Parametrised successor to the ASCII file-load keyboard source for the Apple-I core.
- Captures a text file streamed over the ioctl download port into an internal buffer of configurable depth.
- Replays the buffer as keystrokes through the PIA keyboard register pair (RX data / RX status), using an internal pacing timer rather than an external key clock.
- Adds end-of-line normalisation, optional upper-casing, extra post-CR delay, abort, and overflow reporting.

Parameters:
- AW, 13: buffer address width; depth = 2**AW bytes.
- CHAR_GAP, 25000: clk25 cycles between a CPU data read and presentation of the next character (1 ms).
- CR_GAP, 2500000: clk25 cycles of gap after a CR is consumed (100 ms), for BASIC line entry.
- GAPW, 22: width of the pacing counter; must hold max(CHAR_GAP, CR_GAP).

Ports:
- clk25 in 1: 25 MHz system clock.
- rst in 1: reset, asynchronous, active-high.
- ioctl_download in 1: high for the duration of a text file transfer.
- ioctl_wr in 1: write strobe, one cycle per byte.
- ioctl_addr in AW+1: byte address within the file.
- ioctl_dout in 8: file byte.
- abort in 1: single-cycle pulse that cancels playback.
- upcase_en in 1: when 1, 'a'..'z' are converted to 'A'..'Z'.
- cs in 1: CPU chip select for the keyboard registers, active-high.
- address in 1: register select; 0 = RX data, 1 = RX status.
- dout out 8: registered read data.
- busy out 1: high in LOAD and in every playback state.
- overflow out 1: sticky; file exceeded the buffer depth.

Behaviour:
- Reset values:
  - state = IDLE.
  - dout = 8'h00; busy = 0; overflow = 0.
  - rdy = 0, ptr = 0, count = 0, gap counter = 0, ascii = 8'h00, prev_cr = 0.
- Storage: inferred single-port-write / single-port-read block RAM, 2**AW x 8, synchronous read with 1-cycle latency.
- States: IDLE, LOAD, GAP, FETCH, EVAL, PRESENT.
- IDLE:
  - Rising level of ioctl_download -> LOAD.
  - On entry to LOAD: count = 0, ptr = 0, overflow = 0, rdy = 0.
- LOAD:
  - ioctl_wr with ioctl_addr < 2**AW: write the byte; count = max(count, ioctl_addr + 1).
  - ioctl_wr with ioctl_addr >= 2**AW: write is discarded and overflow = 1.
  - ioctl_download low: count == 0 -> IDLE; otherwise -> GAP with the counter loaded to CHAR_GAP.
- GAP: counter decrements each cycle; at 0 -> FETCH.
- FETCH:
  - ptr == count -> IDLE.
  - Otherwise issue the RAM read at ptr and -> EVAL next cycle; ptr increments.
- EVAL (translation of RAM byte b):
  - b == 8'h00 -> skip (back to FETCH).
  - b == 8'h0A with prev_cr == 1 -> skip (collapses CRLF); prev_cr = 0.
  - b == 8'h0A otherwise -> emit 8'h0D.
  - b == 8'h0D -> emit 8'h0D and set prev_cr = 1.
  - Any other byte -> prev_cr = 0; upcase_en && b in 8'h61..8'h7A -> emit b - 8'h20, else emit b.
  - Emit: latch ascii, set rdy = 1, -> PRESENT.
- PRESENT:
  - Waits indefinitely for a CPU data read (cs && address == 0), which clears rdy.
  - If the consumed char was 8'h0D, the gap counter loads CR_GAP, else CHAR_GAP; -> GAP.
- CPU port: evaluated every cycle, independent of state.
  - cs && address == 0: dout <= {1'b1, ascii[6:0]}; rdy <= 0.
  - cs && address == 1: dout <= {rdy, 7'b0}.
  - cs == 0: dout holds its value.
- Latency:
  - Download end -> first rdy = CHAR_GAP + 3 cycles.
  - Data read -> next rdy = gap + 3 cycles; each skipped byte adds 2.
- Boundary cases:
  - A new ioctl_download in any state -> LOAD with reset of count, ptr, rdy and prev_cr (restart, no merge).
  - abort in any state except LOAD -> IDLE with rdy = 0; buffer contents are kept but not replayed.
  - abort in LOAD is ignored.
  - Simultaneous abort and data read: dout is updated, then the machine goes to IDLE.
  - Sparse or out-of-order ioctl_addr: count follows the highest address; unwritten holes replay stale RAM bytes (NULs are skipped).
  - A file of exactly 2**AW bytes gives count = 2**AW (AW+1 bits) and no overflow.
  - A status read never clears rdy.

Decomposition:
- Shared package apple1_kbd_pkg:
  - Constants: ASCII_LF = 8'h0A, ASCII_CR = 8'h0D, ASCII_NUL = 8'h00.
  - State encoding enum.
  - Register select constants REG_RX_DATA = 0, REG_RX_STATUS = 1.
- One sub-module, text_buf_ram: parametrised AW, synchronous write, registered read.

Test Plan:
1. Load "AB\n" with AW=4, CHAR_GAP=4, then poll status and read data each time status bit 7 is set -> reads 8'hC1, 8'hC2, 8'h8D; busy falls after the third read.
2. Load "a\r\nb" with upcase_en=1 -> reads 8'hC1, 8'h8D, 8'hC2 (LF dropped); the gap after 8'h8D measures CR_GAP + 3 cycles.
3. Load 17 bytes with AW=4 -> overflow = 1; exactly 16 chars are replayed. Then load 16 bytes -> overflow = 0 and 16 chars are replayed.
4. Assert abort while in PRESENT -> status reads 8'h00 the next cycle, busy = 0, and no further characters appear.
5. Start a new download mid-playback with file "Z" -> the old sequence stops and only 8'hDA is delivered.
6. Assert rst asynchronously mid-GAP -> dout, busy, overflow and rdy are 0 immediately; after release the block stays in IDLE.
